// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//
// Round-robin arbiter for three requesters that share one 2-bit symbol mux.
// A winner keeps the mux for a burst of up to BURST_LEN cycles, or less if it
// drops its request. After each burst the bus stays idle for GAP_CYCLES cycles,
// then arbitration runs again. Every output is registered, so there is no
// combinational path from req to any output.
//
// Parameters
//   BURST_LEN  (1..15) maximum granted cycles per burst
//   GAP_CYCLES (0..3)  idle cycles inserted after every burst
//
// Ports
//   clk       in   single clock, all state on the rising edge
//   rst       in   synchronous active-high reset
//   req[2:0]  in   level request per requester
//   lock[2:0] in   burst-extend hold per requester (MUX_SEL_ARBITER_LOCK_EN only)
//   sB, sA    out  mux select {sB,sA}: 00/01/10 = requester 0/1/2, 11 = idle
//   grant     out  one-hot grant, 000 when idle
//   tx_active out  high whenever grant is non-zero
//
// Build option
//   MUX_SEL_ARBITER_LOCK_EN: adds the lock input. While the granted requester
//   holds both req and lock, the BURST_LEN limit is ignored and the counter
//   saturates at 15. The burst then ends when req drops, or when lock drops
//   once the count has reached BURST_LEN.
//
// Handshake: req is a level, not a pulse. A request is served once it has been
// sampled high at a rising edge. The grant appears on the next cycle and stays
// while req remains high, up to the burst limit.

module mux_sel_arbiter #(
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
`ifdef MUX_SEL_ARBITER_LOCK_EN
    input  logic [2:0] lock,
`endif
    output logic       sB,
    output logic       sA,
    output logic [2:0] grant,
    output logic       tx_active
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);
    localparam logic [1:0] GAP_LAST  = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] count, count_nx;
    logic [1:0] last, last_nx;       // index of the most recently granted requester
    logic [1:0] gap_cnt, gap_cnt_nx;
    logic [2:0] grant_nx;

    // Round-robin pick: the search starts just after the last winner, so the
    // last winner always ranks lowest.
    logic [1:0] p0, p1, p2;
    logic [1:0] pick_idx;
    logic       pick_hit;

    always_comb begin
        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        pick_hit = |req;
        if (req[p0])      pick_idx = p0;
        else if (req[p1]) pick_idx = p1;
        else              pick_idx = p2;
    end

    // Index of the current owner, recovered from the one-hot grant register.
    logic [1:0] owner;
    logic       owner_held;
    logic       burst_done;

    always_comb begin
        if (grant[1])      owner = 2'd1;
        else if (grant[2]) owner = 2'd2;
        else               owner = 2'd0;
`ifdef MUX_SEL_ARBITER_LOCK_EN
        owner_held = lock[owner];
`else
        owner_held = 1'b0;
`endif
        burst_done = !req[owner] || ((count >= BURST_MAX) && !owner_held);
    end

    // Next-state logic.
    logic do_arb;

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        last_nx    = last;
        gap_cnt_nx = gap_cnt;
        grant_nx   = grant;
        do_arb     = 1'b0;

        case (state)
            IDLE: do_arb = 1'b1;
            BURST: begin
                if (burst_done) begin
                    if (GAP_CYCLES > 0) begin
                        state_nx   = GAP;
                        grant_nx   = 3'b000;
                        count_nx   = 4'd0;
                        gap_cnt_nx = 2'd0;
                    end else begin
                        // Back-to-back: re-arbitrate on the same edge.
                        do_arb = 1'b1;
                    end
                end else if (count != 4'd15) begin
                    count_nx = count + 4'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) do_arb = 1'b1;
                else                     gap_cnt_nx = gap_cnt + 2'd1;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 3'b000;
                count_nx = 4'd0;
            end
        endcase

        if (do_arb) begin
            gap_cnt_nx = 2'd0;
            if (pick_hit) begin
                state_nx = BURST;
                grant_nx = 3'b001 << pick_idx;
                count_nx = 4'd1;
                last_nx  = pick_idx;
            end else begin
                state_nx = IDLE;
                grant_nx = 3'b000;
                count_nx = 4'd0;
            end
        end
    end

    // The mux select comes from the next grant, so it is registered together
    // with it.
    logic [1:0] sel_nx;

    always_comb begin
        case (grant_nx)
            3'b001:  sel_nx = 2'b00;
            3'b010:  sel_nx = 2'b01;
            3'b100:  sel_nx = 2'b10;
            default: sel_nx = 2'b11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            last      <= 2'd2;
            gap_cnt   <= 2'd0;
            grant     <= 3'b000;
            sB        <= 1'b1;
            sA        <= 1'b1;
            tx_active <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            last      <= last_nx;
            gap_cnt   <= gap_cnt_nx;
            grant     <= grant_nx;
            sB        <= sel_nx[1];
            sA        <= sel_nx[0];
            tx_active <= |grant_nx;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
//
// Drives three arbiter instances from the same req/lock/rst stimulus:
//   inst0: BURST_LEN=4, GAP_CYCLES=1 (defaults)
//   inst1: BURST_LEN=4, GAP_CYCLES=0 (back-to-back grants)
//   inst2: BURST_LEN=1, GAP_CYCLES=2 (single-cycle bursts, long gap)
// A per-instance cycle model tracks the holder, the burst length, the
// remaining gap and the last winner. After each rising edge the model is
// advanced and the outputs are compared with it 1 ns later.

module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst_in;
    logic [2:0] req_in;
    logic [2:0] lock_in;
    logic [2:0] sb_o, sa_o, tx_o;
    logic [2:0][2:0] grant_o;

`ifdef MUX_SEL_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int bl_of [3];
    int gp_of [3];
    int holder [3];
    int cnt [3];
    int gap_left [3];
    int last_win [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_sel_arbiter #(.BURST_LEN(4), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst_in), .req(req_in),
`ifdef MUX_SEL_ARBITER_LOCK_EN
        .lock(lock_in),
`endif
        .sB(sb_o[0]), .sA(sa_o[0]), .grant(grant_o[0]), .tx_active(tx_o[0])
    );

    mux_sel_arbiter #(.BURST_LEN(4), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst_in), .req(req_in),
`ifdef MUX_SEL_ARBITER_LOCK_EN
        .lock(lock_in),
`endif
        .sB(sb_o[1]), .sA(sa_o[1]), .grant(grant_o[1]), .tx_active(tx_o[1])
    );

    mux_sel_arbiter #(.BURST_LEN(1), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst_in), .req(req_in),
`ifdef MUX_SEL_ARBITER_LOCK_EN
        .lock(lock_in),
`endif
        .sB(sb_o[2]), .sA(sa_o[2]), .grant(grant_o[2]), .tx_active(tx_o[2])
    );

    // Reference model: one step per rising edge, using the inputs sampled there.
    task automatic model_step();
        bit arb;
        bit keep;
        int h;
        int idx;
        for (int m = 0; m < 3; m++) begin
            arb = 1'b0;
            if (rst_in) begin
                holder[m] = -1; cnt[m] = 0; gap_left[m] = 0; last_win[m] = 2;
            end else begin
                if (holder[m] >= 0) begin
                    h = holder[m];
                    keep = req_in[h] && ((cnt[m] < bl_of[m]) || (LOCK_EN && lock_in[h]));
                    if (keep) begin
                        cnt[m] = (cnt[m] < 15) ? cnt[m] + 1 : 15;
                    end else begin
                        holder[m] = -1;
                        cnt[m] = 0;
                        if (gp_of[m] > 0) gap_left[m] = gp_of[m];
                        else arb = 1'b1;
                    end
                end else if (gap_left[m] > 0) begin
                    gap_left[m] = gap_left[m] - 1;
                    if (gap_left[m] == 0) arb = 1'b1;
                end else begin
                    arb = 1'b1;
                end
                if (arb) begin
                    for (int k = 1; k <= 3; k++) begin
                        idx = (last_win[m] + k) % 3;
                        if (holder[m] < 0 && req_in[idx]) begin
                            holder[m] = idx; cnt[m] = 1; last_win[m] = idx;
                        end
                    end
                end
            end
        end
    endtask

    // Expected {sB, sA, tx_active, grant} for instance m.
    function automatic logic [5:0] exp_out(int m);
        logic [1:0] sel;
        logic [2:0] g;
        if (holder[m] < 0) return 6'b11_0_000;
        sel = 2'(holder[m]);
        g = 3'b001 << holder[m];
        return {sel, 1'b1, g};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // One-hot-or-zero grant, with select and tx_active consistent with it,
    // on every cycle of every run.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int m = 0; m < 3; m++) begin
                logic [1:0] want_sel;
                case (grant_o[m])
                    3'b001:  want_sel = 2'b00;
                    3'b010:  want_sel = 2'b01;
                    3'b100:  want_sel = 2'b10;
                    default: want_sel = 2'b11;
                endcase
                checks++;
                if (!$onehot0(grant_o[m]) || {sb_o[m], sa_o[m]} !== want_sel || tx_o[m] !== (|grant_o[m])) begin
                    errors++;
                    $display("FAIL invariant inst%0d t=%0t: grant=%b sel=%b%b tx=%b, required sel=%b tx=%b",
                             m, $time, grant_o[m], sb_o[m], sa_o[m], tx_o[m], want_sel, |grant_o[m]);
                end
            end
        end
    end

    task automatic test_reset();
        rst_in = 1'b1; req_in = 3'b111; lock_in = 3'b000;
        for (int c = 0; c < 3; c++) begin
            tick();
            mon_en = 1'b1;
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== 6'b11_0_000) begin
                    errors++;
                    $display("FAIL reset inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, 6'b11_0_000);
                end
            end
        end
        rst_in = 1'b0; req_in = 3'b000;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL reset_idle inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask

    task automatic test_single_hold();
        logic [2:0] want0 [6];
        want0 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        tick();
        rst_in = 1'b0; req_in = 3'b001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 6) begin
                checks++;
                if (grant_o[0] !== want0[c-1]) begin
                    errors++;
                    $display("FAIL single_hold inst0 cyc%0d: grant=%b required %b", c, grant_o[0], want0[c-1]);
                end
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL single_hold_model inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        tick();
        rst_in = 1'b0; req_in = 3'b111;
        for (int c = 1; c <= 16; c++) begin
            tick();
            want = 3'b001 << (((c - 1) / 4) % 3);
            checks++;
            if (grant_o[1] !== want) begin
                errors++;
                $display("FAIL round_robin inst1 cyc%0d: grant=%b required %b", c, grant_o[1], want);
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL round_robin_model inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask

    task automatic test_early_end();
        logic [2:0] want0 [4];
        want0 = '{3'b010, 3'b010, 3'b000, 3'b000};
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        tick();
        rst_in = 1'b0; req_in = 3'b010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) req_in = 3'b000;
            checks++;
            if (grant_o[0] !== want0[c-1]) begin
                errors++;
                $display("FAIL early_end inst0 cyc%0d: grant=%b required %b", c, grant_o[0], want0[c-1]);
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL early_end_model inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        tick();
        rst_in = 1'b0; req_in = 3'b100;
        tick(); tick(); tick();
        checks++;
        if (grant_o[0] !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_setup inst0: grant=%b required %b", grant_o[0], 3'b100);
        end
        rst_in = 1'b1; req_in = 3'b101;
        tick();
        checks++;
        if ({sb_o[0], sa_o[0], tx_o[0], grant_o[0]} !== 6'b11_0_000) begin
            errors++;
            $display("FAIL mid_reset_abort inst0: got %b required %b",
                     {sb_o[0], sa_o[0], tx_o[0], grant_o[0]}, 6'b11_0_000);
        end
        rst_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (grant_o[0] !== 3'b001) begin
                    errors++;
                    $display("FAIL mid_reset_first inst0: grant=%b required %b", grant_o[0], 3'b001);
                end
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL mid_reset_model inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask

`ifdef MUX_SEL_ARBITER_LOCK_EN
    task automatic test_lock();
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        tick();
        rst_in = 1'b0; req_in = 3'b010; lock_in = 3'b010;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 10) lock_in = 3'b000;
            checks++;
            if (grant_o[0] !== ((c <= 10) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL lock inst0 cyc%0d: grant=%b required %b", c, grant_o[0],
                         (c <= 10) ? 3'b010 : 3'b000);
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL lock_model inst%0d cyc%0d: got %b required %b", m, c,
                             {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) req_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) lock_in = 3'($urandom_range(0, 7));
            rst_in = ($urandom_range(0, 59) == 0);
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({sb_o[m], sa_o[m], tx_o[m], grant_o[m]} !== exp_out(m)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d req=%b lock=%b: got %b required %b", m, c,
                             req_in, lock_in, {sb_o[m], sa_o[m], tx_o[m], grant_o[m]}, exp_out(m));
                end
            end
        end
    endtask

    initial begin
        bl_of = '{4, 4, 1};
        gp_of = '{1, 0, 2};
        for (int m = 0; m < 3; m++) begin
            holder[m] = -1; cnt[m] = 0; gap_left[m] = 0; last_win[m] = 2;
        end
        rst_in = 1'b1; req_in = 3'b000; lock_in = 3'b000;
        test_reset();
        test_single_hold();
        test_round_robin();
        test_early_end();
        test_reset_mid_burst();
`ifdef MUX_SEL_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
